// File: rtl/line_assembler.sv
// line_assembler: packs a pixel stream into full lines with zeroed borders and row tracking.
// Optional double-buffered output when LINE_ASM_DBUF_EN is defined.
module line_assembler #(
    parameter int LINE_W = 320,
    parameter int PIX_W  = 1,
    parameter int BORDER = 2,
    parameter int ROWS   = 240,
    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sof,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    pix_ready,
    output logic [LINE_W*PIX_W-1:0] line_pixel,
    output logic                    line_valid,
    output logic [ROW_W-1:0]        row_idx,
    output logic                    frame_end,
    output logic                    start
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [ROW_W-1:0]          row_idx_q, row_idx_d;
    logic [LINE_W*PIX_W-1:0]   work_q, work_d;
    logic                      line_valid_q, line_valid_d;
    logic                      frame_end_q, frame_end_d;
    logic                      start_q, start_d;
    logic                      xfer, in_win, last_col, last_row;
`ifdef LINE_ASM_DBUF_EN
    logic [LINE_W*PIX_W-1:0]   shadow_q, shadow_d;
`endif

    assign pix_ready = (state_q == FILL) && en;
    assign xfer      = pix_valid && pix_ready;
    assign in_win    = (col_q >= COL_W'(BORDER)) && (col_q <= COL_W'(LINE_W - BORDER - 1));
    assign last_col  = col_q == COL_W'(LINE_W - 1);
    assign last_row  = row_q == ROW_W'(ROWS - 1);

    assign line_valid = line_valid_q;
    assign frame_end  = frame_end_q;
    assign start      = start_q;
    assign row_idx    = row_idx_q;
`ifdef LINE_ASM_DBUF_EN
    assign line_pixel = shadow_q;
`else
    assign line_pixel = work_q;
`endif

    // Next-state logic: line fill, completion pulse, abort on en low, frame restart on sof.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row_idx_d    = row_idx_q;
        work_d       = work_q;
        line_valid_d = 1'b0;
        frame_end_d  = 1'b0;
        start_d      = 1'b0;
`ifdef LINE_ASM_DBUF_EN
        shadow_d     = shadow_q;
`endif
        if (!en) begin
            state_d = IDLE;
            col_d   = '0;
            work_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    start_d = 1'b1;
                end
                FILL: begin
                    if (xfer && sof) begin
                        col_d              = COL_W'(1);
                        row_d              = '0;
                        work_d             = '0;
                        work_d[PIX_W-1:0]  = (BORDER > 0) ? '0 : pix_data;
                    end else if (xfer) begin
                        work_d[col_q*PIX_W +: PIX_W] = in_win ? pix_data : '0;
                        if (last_col) begin
                            state_d      = DONE;
                            col_d        = '0;
                            line_valid_d = 1'b1;
                            row_idx_d    = row_q;
                            frame_end_d  = last_row;
                            row_d        = last_row ? '0 : row_q + 1'b1;
`ifdef LINE_ASM_DBUF_EN
                            shadow_d     = work_d;
`endif
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = FILL;
                    start_d = 1'b1;
`ifdef LINE_ASM_DBUF_EN
                    work_d  = '0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            row_idx_q    <= '0;
            work_q       <= '0;
            line_valid_q <= 1'b0;
            frame_end_q  <= 1'b0;
            start_q      <= 1'b0;
`ifdef LINE_ASM_DBUF_EN
            shadow_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_idx_q    <= row_idx_d;
            work_q       <= work_d;
            line_valid_q <= line_valid_d;
            frame_end_q  <= frame_end_d;
            start_q      <= start_d;
`ifdef LINE_ASM_DBUF_EN
            shadow_q     <= shadow_d;
`endif
        end
    end
endmodule

// File: tb/tb_line_assembler.sv
// tb_line_assembler: randomized and directed checks of line_assembler against a line-level model.
module tb_line_assembler;
    localparam int LW  = 8;
    localparam int PW  = 1;
    localparam int BD  = 2;
    localparam int RW  = 3;
    localparam int RIW = $clog2(RW);
`ifdef LINE_ASM_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sof = 1'b0;
    logic pix_valid = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic pix_ready, line_valid, frame_end, start;
    logic [LW*PW-1:0] line_pixel;
    logic [RIW-1:0] row_idx;

    line_assembler #(.LINE_W(LW), .PIX_W(PW), .BORDER(BD), .ROWS(RW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .line_pixel(line_pixel),
        .line_valid(line_valid), .row_idx(row_idx), .frame_end(frame_end), .start(start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // line-level model: 0 waiting for enable, 1 collecting pixels, 2 line just completed
    int m_phase, m_col, m_row, e_row;
    logic [PW-1:0] m_buf [LW];
    logic [PW-1:0] m_shown [LW];
    bit e_lv, e_fe, e_start, took;
    logic [LW*PW-1:0] bmask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW*PW-1:0] exp_line();
        logic [LW*PW-1:0] v;
        for (int i = 0; i < LW; i++) v[i*PW +: PW] = DBUF ? m_shown[i] : m_buf[i];
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_col = 0; m_row = 0; e_row = 0;
        e_lv = 0; e_fe = 0; e_start = 0;
        for (int i = 0; i < LW; i++) begin
            m_buf[i] = '0;
            m_shown[i] = '0;
        end
    endtask

    task automatic model_step();
        e_lv = 0; e_fe = 0; e_start = 0;
        if (!en) begin
            m_phase = 0; m_col = 0;
            for (int i = 0; i < LW; i++) m_buf[i] = '0;
        end else if (m_phase == 0) begin
            m_phase = 1; e_start = 1;
        end else if (m_phase == 2) begin
            m_phase = 1; e_start = 1;
            if (DBUF) for (int i = 0; i < LW; i++) m_buf[i] = '0;
        end else if (took && sof) begin
            for (int i = 0; i < LW; i++) m_buf[i] = '0;
            m_buf[0] = (BD > 0) ? '0 : pix_data;
            m_col = 1; m_row = 0;
        end else if (took) begin
            m_buf[m_col] = (m_col >= BD && m_col < LW - BD) ? pix_data : '0;
            if (m_col == LW - 1) begin
                m_phase = 2; m_col = 0;
                e_lv = 1; e_row = m_row; e_fe = (m_row == RW - 1);
                m_row = (m_row + 1) % RW;
                for (int i = 0; i < LW; i++) m_shown[i] = m_buf[i];
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic compare_outputs();
        chk("line_valid", line_valid, e_lv);
        chk("frame_end", frame_end, e_fe);
        chk("start", start, e_start);
        chk("row_idx", row_idx, e_row);
        chk("line_pixel", line_pixel, exp_line());
        chk("border_zero", line_pixel & bmask, 0);
    endtask

    task automatic cycle();
        bit rdy;
        #1;
        rdy = rst_n && en && (m_phase == 1);
        chk("pix_ready", pix_ready, rdy);
        took = rdy && pix_valid;
        if (!rst_n) model_reset(); else model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic send(input logic [PW-1:0] d, input bit s);
        int n;
        pix_valid = 1'b1; pix_data = d; sof = s; took = 0; n = 0;
        while (!took && n < 10) begin
            cycle();
            n++;
        end
        chk("send_accepted", took, 1);
        sof = 1'b0;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        bmask = '0;
        for (int i = 0; i < LW; i++) if (i < BD || i >= LW - BD) bmask[i*PW +: PW] = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        chk("rst_ready", pix_ready, 0);
        rst_n = 1'b1;
        en = 1'b1;
        cycle();
        chk("start_before", start, 1);
        send(PW'(1), 1'b1);
        for (int i = 1; i < LW; i++) begin
            send(PW'(1), 1'b0);
            if (i == 3) begin
                if (DBUF) chk("dbuf_stable", line_pixel, 0);
                else chk("live_bit3", line_pixel[3], 1);
            end
        end
        chk("l0_pixel", line_pixel, 8'b00111100);
        chk("l0_model", exp_line(), 8'b00111100);
        chk("l0_valid", line_valid, 1);
        chk("l0_row", row_idx, 0);
        pix_valid = 1'b0;
        cycle();
        chk("start_after", start, 1);
        for (int ln = 1; ln <= 3; ln++) begin
            for (int i = 0; i < LW; i++) send(PW'($urandom), 1'b0);
            chk("rows_row", row_idx, ln % 3);
            chk("rows_fe", frame_end, ln == 2);
            chk("rows_lv", line_valid, 1);
        end
        for (int i = 0; i < 4; i++) send(PW'(1), 1'b0);
        en = 1'b0;
        pix_valid = 1'b0;
        cycle();
        chk("abort_no_lv", line_valid, 0);
        en = 1'b1;
        for (int i = 0; i < LW; i++) send(PW'(i % 2 == 0 ? 1 : 0), 1'b0);
        chk("alt_pixel", line_pixel, 8'b00010100);
        chk("alt_model", exp_line(), 8'b00010100);
        chk("alt_row", row_idx, 1);
        for (int i = 0; i < 5; i++) send(PW'(1), 1'b0);
        send(PW'(1), 1'b1);
        for (int i = 0; i < 6; i++) send(PW'(1), 1'b0);
        chk("sof_no_lv", line_valid, 0);
        send(PW'(1), 1'b0);
        chk("sof_lv", line_valid, 1);
        chk("sof_row", row_idx, 0);
        pix_valid = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) send(PW'(1), 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        chk("rst_async_ready", pix_ready, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        pix_valid = 1'b0;
        cycle();
        chk("start_after_rst", start, 1);
        repeat (3000) begin
            en = ($urandom % 64) != 0;
            sof = ($urandom % 32) == 0;
            pix_valid = ($urandom % 4) != 0;
            pix_data = PW'($urandom);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
